// File: rtl/mem_responder_pkg.sv
// Shared definitions for the byte-addressable memory responder.
// Holds the request size codes, the responder FSM state encoding and
// the storage depth.
package mem_responder_pkg;

  localparam int unsigned MEM_WORDS = 64;
  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    SZ_WORD    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_BYTE    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_MERGE = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/mem_lane_merge.sv
// Combinational lane logic for little-endian sub-word accesses.
// Ports:
//   i_old    - word currently held in storage
//   i_wdata  - right-justified store data
//   i_size   - access size code
//   i_addr   - byte offset within the word
//   o_merged - i_old with the addressed lanes replaced by i_wdata
//   o_rdata  - addressed lanes of i_old, right-justified, zero-extended
module mem_lane_merge
  import mem_responder_pkg::*;
(
  input  logic [31:0] i_old,
  input  logic [31:0] i_wdata,
  input  size_e       i_size,
  input  logic [1:0]  i_addr,
  output logic [31:0] o_merged,
  output logic [31:0] o_rdata
);

  always_comb begin
    o_merged = i_old;
    o_rdata  = '0;
    case (i_size)
      SZ_WORD: begin
        o_merged = i_wdata;
        o_rdata  = i_old;
      end
      SZ_HALF: begin
        o_merged[{i_addr[1], 4'b0000} +: 16] = i_wdata[15:0];
        o_rdata[15:0] = i_old[{i_addr[1], 4'b0000} +: 16];
      end
      SZ_BYTE: begin
        o_merged[{i_addr, 3'b000} +: 8] = i_wdata[7:0];
        o_rdata[7:0] = i_old[{i_addr, 3'b000} +: 8];
      end
      default: begin
        o_merged = i_old;
        o_rdata  = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder over a 64 x 32-bit little-endian
// array. Loads take IDLE->READ->RESP, stores read-modify-write through
// IDLE->READ->MERGE->RESP, rejected requests go IDLE->RESP directly.
// Ports:
//   clk, reset           - clock, synchronous active-low reset
//   req_valid/req_ready  - request handshake (ready only in IDLE)
//   req_we, req_size     - store flag, access size code
//   req_addr, req_wdata  - byte address, right-justified store data
//   rsp_valid            - one-cycle completion pulse
//   rsp_rdata, rsp_err   - load data / rejection flag, valid with rsp_valid
module mem_responder
  import mem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  state_e      r_state;
  state_e      w_next;

  logic        r_we;
  size_e       r_size;
  logic [7:0]  r_addr;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [31:0] r_word;

  logic        w_accept;
  logic        w_req_err;
  logic [31:0] w_merged;
  logic [31:0] w_load;

  logic [31:0] r_mem [MEM_WORDS];

  // Out-of-range address, illegal size or misalignment.
  always_comb begin
    w_req_err = 1'b0;
    if (req_addr[31:8] != '0)                                    w_req_err = 1'b1;
    if (size_e'(req_size) == SZ_ILLEGAL)                         w_req_err = 1'b1;
    if (size_e'(req_size) == SZ_HALF && req_addr[0])             w_req_err = 1'b1;
    if (size_e'(req_size) == SZ_WORD && req_addr[1:0] != 2'b00)  w_req_err = 1'b1;
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          w_next   = w_req_err ? ST_RESP : ST_READ;
        end
      end
      ST_READ:  w_next = r_we ? ST_MERGE : ST_RESP;
      ST_MERGE: w_next = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = r_err;
        rsp_rdata = (r_err || r_we) ? '0 : w_load;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_size  <= SZ_WORD;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_word  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= req_we;
        r_size  <= size_e'(req_size);
        r_addr  <= req_addr[7:0];
        r_wdata <= req_wdata;
        r_err   <= w_req_err;
      end
      if (r_state == ST_READ) begin
        r_word <= r_mem[r_addr[7:2]];
      end
    end
  end

  // Storage is never reset; a reset landing in MERGE suppresses the write.
  always_ff @(posedge clk) begin
    if (reset && r_state == ST_MERGE) begin
      r_mem[r_addr[7:2]] <= w_merged;
    end
  end

  mem_lane_merge u_lane (
    .i_old    (r_word),
    .i_wdata  (r_wdata),
    .i_size   (r_size),
    .i_addr   (r_addr[1:0]),
    .o_merged (w_merged),
    .o_rdata  (w_load)
  );

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  vec_t vt[21];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Issues one request from IDLE; returns the response and the number of
  // rising edges from accept until the edge that samples rsp_valid high.
  task automatic do_req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                        output int lat, output logic busy_ready);
    err = 1'bx;
    rdata = 'x;
    lat = 0;
    busy_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_size  = $urandom_range(0, 3);
    req_addr  = $urandom;
    req_wdata = $urandom;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (req_ready) busy_ready = 1'b1;
      if (rsp_valid) begin
        lat   = k;
        err   = rsp_err;
        rdata = rsp_rdata;
        break;
      end
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    logic        err;
    logic [31:0] rdata;
    int          lat;
    logic        busy;
    do_req(v.we, v.size, v.addr, v.wdata, err, rdata, lat, busy);
    chk({name, ".lat"}, lat, v.lat);
    chk({name, ".err"}, {31'b0, err}, {31'b0, v.err});
    chk({name, ".rdata"}, rdata, v.rdata);
    chk({name, ".busy_ready"}, {31'b0, busy}, 32'h0);
    @(negedge clk);
    chk({name, ".after"}, {30'b0, rsp_valid, req_ready}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic        err;
    logic [31:0] rdata;
    int          lat;
    logic        busy;

    //            we    size   addr        wdata          err   rdata          lat
    vt[0]  = '{1'b1, 2'b00, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        3};
    vt[1]  = '{1'b0, 2'b00, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 2};
    vt[2]  = '{1'b1, 2'b10, 32'h12,  32'h00000055, 1'b0, 32'h0,        3};
    vt[3]  = '{1'b0, 2'b00, 32'h10,  32'h0,        1'b0, 32'hDE55BEEF, 2};
    vt[4]  = '{1'b0, 2'b10, 32'h13,  32'h0,        1'b0, 32'h000000DE, 2};
    vt[5]  = '{1'b1, 2'b01, 32'h11,  32'h00001234, 1'b1, 32'h0,        1};
    vt[6]  = '{1'b0, 2'b00, 32'h10,  32'h0,        1'b0, 32'hDE55BEEF, 2};
    vt[7]  = '{1'b0, 2'b00, 32'h100, 32'h0,        1'b1, 32'h0,        1};
    vt[8]  = '{1'b0, 2'b01, 32'h12,  32'h0,        1'b0, 32'h0000DE55, 2};
    vt[9]  = '{1'b0, 2'b01, 32'h10,  32'h0,        1'b0, 32'h0000BEEF, 2};
    vt[10] = '{1'b0, 2'b10, 32'h11,  32'h0,        1'b0, 32'h000000BE, 2};
    vt[11] = '{1'b1, 2'b01, 32'h12,  32'hFFFFABCD, 1'b0, 32'h0,        3};
    vt[12] = '{1'b0, 2'b00, 32'h10,  32'h0,        1'b0, 32'hABCDBEEF, 2};
    vt[13] = '{1'b0, 2'b11, 32'h10,  32'h0,        1'b1, 32'h0,        1};
    vt[14] = '{1'b0, 2'b00, 32'h12,  32'h0,        1'b1, 32'h0,        1};
    vt[15] = '{1'b1, 2'b00, 32'h20,  32'h11111111, 1'b0, 32'h0,        3};
    vt[16] = '{1'b1, 2'b00, 32'hFC,  32'h00000000, 1'b0, 32'h0,        3};
    vt[17] = '{1'b1, 2'b10, 32'hFF,  32'hFFFFFF77, 1'b0, 32'h0,        3};
    vt[18] = '{1'b0, 2'b00, 32'hFC,  32'h0,        1'b0, 32'h77000000, 2};
    vt[19] = '{1'b0, 2'b10, 32'hFF,  32'h0,        1'b0, 32'h00000077, 2};
    vt[20] = '{1'b1, 2'b10, 32'h1000_0010, 32'h0,  1'b1, 32'h0,        1};

    reset     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("reset.ready", {31'b0, req_ready}, 32'h1);
    chk("reset.valid", {31'b0, rsp_valid}, 32'h0);
    chk("reset.err",   {31'b0, rsp_err},   32'h0);
    chk("reset.rdata", rsp_rdata,          32'h0);

    for (int i = 0; i < 21; i++) begin
      run_vec($sformatf("vec%0d", i), vt[i]);
    end

    // Held request: second load accepted on the edge right after RESP.
    begin
      logic       exp_rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic       exp_vld [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_size  = 2'b00;
      req_addr  = 32'h10;
      req_wdata = '0;
      for (int c = 0; c < 7; c++) begin
        if (c > 0) @(negedge clk);
        chk($sformatf("b2b.ready%0d", c), {31'b0, req_ready}, {31'b0, exp_rdy[c]});
        chk($sformatf("b2b.valid%0d", c), {31'b0, rsp_valid}, {31'b0, exp_vld[c]});
        if (exp_vld[c]) chk($sformatf("b2b.rdata%0d", c), rsp_rdata, 32'hABCDBEEF);
        if (c == 3) begin
          @(posedge clk);
          #1 req_valid = 1'b0;
        end
      end
    end

    // Reset during MERGE: write suppressed, no response.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b00;
    req_addr  = 32'h20;
    req_wdata = 32'hAAAAAAAA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("rst_merge.ready", {31'b0, req_ready}, 32'h1);
    begin
      logic seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (rsp_valid) seen = 1'b1;
        @(negedge clk);
      end
      chk("rst_merge.no_rsp", {31'b0, seen}, 32'h0);
    end
    do_req(1'b0, 2'b00, 32'h20, 32'h0, err, rdata, lat, busy);
    chk("rst_merge.load", rdata, 32'h11111111);
    chk("rst_merge.lat", lat, 2);

    // Reset during READ: aborted, no write.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b00;
    req_addr  = 32'h20;
    req_wdata = 32'h22222222;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("rst_read.ready", {31'b0, req_ready}, 32'h1);
    chk("rst_read.valid", {31'b0, rsp_valid}, 32'h0);
    repeat (3) @(negedge clk);
    do_req(1'b0, 2'b00, 32'h20, 32'h0, err, rdata, lat, busy);
    chk("rst_read.load", rdata, 32'h11111111);
    chk("rst_read.err", {31'b0, err}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 clk  in  1  -- sole clock; all state updates on rising edge.
REQ-002 reset  in  1  -- synchronous, active-low; sampled on rising edge of clk.
REQ-003 req_valid  in  1  -- initiator presents a request.
REQ-004 req_ready  out  1  -- responder can accept; a request transfers when req_valid && req_ready at a rising edge.
REQ-005 req_we  in  1  -- 1 = store, 0 = load.
REQ-006 req_size  in  2  -- 00 word, 01 halfword, 10 byte; 11 illegal.
REQ-007 req_addr  in  32  -- byte address.
REQ-008 req_wdata  in  32  -- store data, right-justified: byte in [7:0], half in [15:0].
REQ-009 rsp_valid  out  1  -- one-cycle pulse marking response completion.
REQ-010 rsp_rdata  out  32  -- load data, zero-extended and right-justified; 0 for stores and errors.
REQ-011 rsp_err  out  1  -- request rejected; meaningful only while rsp_valid=1.

Function
REQ-012 Storage SHALL be 64 words x 32 bits (256 bytes), little-endian: byte k of a word sits at bits [8k+7:8k].
REQ-013 FSM states SHALL be IDLE, READ, MERGE, RESP.
REQ-014 req_ready SHALL be 1 only in IDLE; requests in any other state are ignored, not queued.
REQ-015 On accept, req_we, req_size, req_addr and req_wdata SHALL be captured into internal registers; later input changes have no effect on the request.
REQ-016 Error on accept: req_addr[31:8]!=0, or req_size=11, or half with addr[0]=1, or word with addr[1:0]!=0. The FSM SHALL go IDLE->RESP with rsp_err=1 and no array access.
REQ-017 Legal load: IDLE->READ (array word read at addr[7:2])->RESP; rsp_valid SHALL assert exactly 2 cycles after the accept edge.
REQ-018 Load data SHALL be: word = full word; half = word[16*addr[1]+15 : 16*addr[1]]; byte = word[8*addr[1:0]+7 : 8*addr[1:0]]; upper bits zero.
REQ-019 Legal store: IDLE->READ (fetch old word)->MERGE (replace only the addressed byte/half lanes, write the word back)->RESP; rsp_valid SHALL assert 3 cycles after accept.
REQ-020 The array SHALL be written only in MERGE; non-addressed lanes SHALL keep their old values.
REQ-021 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE; req_ready rises in the cycle after RESP.
REQ-022 Outside RESP, rsp_valid=0, rsp_err=0 and rsp_rdata=0.
REQ-023 Back-to-back: a request held valid through RESP SHALL be accepted on the first IDLE edge; throughput is therefore 1 load per 3 cycles and 1 store per 4 cycles.
REQ-024 A load that follows a store to the same word SHALL return the merged data.

Reset
REQ-025 With reset=0 at a rising edge: state=IDLE, req_ready=1 in the following cycle, rsp_valid=0, rsp_err=0, rsp_rdata=0, and captured request registers cleared.
REQ-026 Reset SHALL NOT clear the storage array.
REQ-027 Reset asserted in READ SHALL abort the request with no array write. Reset asserted in MERGE SHALL take precedence and suppress that cycle's write. No response is issued for an aborted request.

Structure
REQ-028 A shared package SHALL hold the size codes (SZ_WORD, SZ_HALF, SZ_BYTE), the state encoding, and the depth constant MEM_WORDS=64.
REQ-029 Lane merge and extract logic SHALL be one combinational sub-module, mem_lane_merge (inputs: old word, wdata, size, addr[1:0]; outputs: merged word, extracted load data). The FSM and array stay in mem_responder.

Verification
REQ-030 Store word 0xDEADBEEF @0x10, then load word @0x10 -> rdata=0xDEADBEEF, err=0; load rsp_valid exactly 2 cycles after its accept.
REQ-031 After REQ-030, store byte 0x55 @0x12, then load word @0x10 -> 0xDE55BEEF; then load byte @0x13 -> 0x000000DE.
REQ-032 Store half 0x1234 @0x11 -> err=1, rsp_valid 1 cycle after accept; word @0x10 is unchanged. Load @0x100 -> err=1, rdata=0.
REQ-033 Hold req_valid=1 continuously for two loads -> the second accept occurs on the edge after RESP; req_ready is never 1 outside IDLE.
REQ-034 Word @0x20 = 0x11111111; store word 0xAAAAAAAA @0x20 and drive reset=0 during MERGE -> no rsp_valid; a subsequent load @0x20 returns 0x11111111.
